// File: rtl/pix_tx_framer.sv
// rtl/pix_tx_framer.sv - CCD pixel buffer and line framer feeding the FT232H TX FIFO
// Frame: A5 5A line_hi line_lo {pix_hi pix_lo}*LINE_PIXELS csum (XOR of pixel bytes).
module pix_tx_framer #(
   parameter int LINE_PIXELS = 2048,
   parameter int DEPTH       = 64
) (
   input  logic        clk_100M,
   input  logic        nrst,
   input  logic        en,
   input  logic        pix_valid,
   input  logic [15:0] pix_data,
   input  logic        tx_full,
   output logic        tx_wrreq,
   output logic [7:0]  tx_data,
   output logic [15:0] line_cnt,
   output logic        ovf
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, LNH, LNL, PXH, PXL, CSUM} state_t;

   state_t      state, state_nx;
   logic [15:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [15:0] head;
   logic [15:0] pix_idx;
   logic [7:0]  lo_byte, csum;
   logic        empty, full, push, pop, byte_ok, last_pix;
   logic        en_q, en_rise, clr_pend, do_clr;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head     = mem[rd_ptr[AW-1:0]];
   assign last_pix = (pix_idx == 16'(LINE_PIXELS - 1));

   // In PXH an empty buffer is only usable once the scan has stopped (zero padding).
   assign byte_ok  = (state != PXH) || !empty || !en;
   assign tx_wrreq = (state != IDLE) && !tx_full && byte_ok;
   assign pop      = (state == PXH) && tx_wrreq && !empty;
   assign push     = pix_valid && en && (!full || pop);

   assign en_rise  = en && !en_q;
   assign do_clr   = (state == IDLE) && (en_rise || clr_pend);

   always_comb begin
      state_nx = state;
      tx_data  = 8'h00;
      case (state)
         IDLE: if (!empty) state_nx = HDR0;
         HDR0: begin
            tx_data = 8'hA5;
            if (tx_wrreq) state_nx = HDR1;
         end
         HDR1: begin
            tx_data = 8'h5A;
            if (tx_wrreq) state_nx = LNH;
         end
         LNH: begin
            tx_data = line_cnt[15:8];
            if (tx_wrreq) state_nx = LNL;
         end
         LNL: begin
            tx_data = line_cnt[7:0];
            if (tx_wrreq) state_nx = PXH;
         end
         PXH: begin
            tx_data = empty ? 8'h00 : head[15:8];
            if (tx_wrreq) state_nx = PXL;
         end
         PXL: begin
            tx_data = lo_byte;
            if (tx_wrreq) state_nx = last_pix ? CSUM : PXH;
         end
         CSUM: begin
            tx_data = csum;
            if (tx_wrreq) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_100M) begin
      if (push) mem[wr_ptr[AW-1:0]] <= pix_data;
   end

   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pix_idx  <= '0;
         lo_byte  <= '0;
         csum     <= '0;
         line_cnt <= '0;
         ovf      <= 1'b0;
         en_q     <= 1'b0;
         clr_pend <= 1'b0;
      end else begin
         state <= state_nx;
         en_q  <= en;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         // A scan restart mid-frame is deferred until the framer is back in IDLE.
         if (do_clr)       clr_pend <= 1'b0;
         else if (en_rise) clr_pend <= 1'b1;

         if (do_clr) ovf <= 1'b0;
         if (pix_valid && en && full && !pop) ovf <= 1'b1;

         if (do_clr)                          line_cnt <= '0;
         else if (state == CSUM && tx_wrreq)  line_cnt <= line_cnt + 16'd1;

         if (state == IDLE) begin
            pix_idx <= '0;
            csum    <= '0;
         end
         if (state == PXH && tx_wrreq) lo_byte <= empty ? 8'h00 : head[7:0];
         if (state == PXL && tx_wrreq) pix_idx <= pix_idx + 16'd1;
         if ((state == PXH || state == PXL) && tx_wrreq) csum <= csum ^ tx_data;
      end
   end

endmodule

// File: tb/tb_pix_tx_framer.sv
// tb/tb_pix_tx_framer.sv - directed scoreboard bench for pix_tx_framer
module tb_pix_tx_framer;

   logic        clk_100M = 1'b0;
   logic        nrst = 1'b0;
   logic        en = 1'b0;
   logic        pix_valid = 1'b0;
   logic [15:0] pix_data = 16'h0000;
   logic        tx_full = 1'b0;
   logic        tx_wrreq;
   logic [7:0]  tx_data;
   logic [15:0] line_cnt;
   logic        ovf;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   logic [7:0]  exp_q[$];
   logic [15:0] px_q[$];
   logic [11:0] full_pat = 12'b0111_0010_1010;
   logic [15:0] ovf_px [6];

   pix_tx_framer #(.LINE_PIXELS(4), .DEPTH(4)) dut (
      .clk_100M (clk_100M),
      .nrst     (nrst),
      .en       (en),
      .pix_valid(pix_valid),
      .pix_data (pix_data),
      .tx_full  (tx_full),
      .tx_wrreq (tx_wrreq),
      .tx_data  (tx_data),
      .line_cnt (line_cnt),
      .ovf      (ovf)
   );

   always #5 clk_100M = ~clk_100M;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Expected frame for the pixels currently in px_q.
   task automatic push_frame(input logic [15:0] ln);
      logic [7:0] cs;
      cs = 8'h00;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(ln[15:8]);
      exp_q.push_back(ln[7:0]);
      foreach (px_q[i]) begin
         exp_q.push_back(px_q[i][15:8]);
         exp_q.push_back(px_q[i][7:0]);
         cs = cs ^ px_q[i][15:8] ^ px_q[i][7:0];
      end
      exp_q.push_back(cs);
   endtask

   task automatic push_pix(input logic [15:0] d);
      pix_valid = 1'b1;
      pix_data  = d;
      @(posedge clk_100M); #1;
      pix_valid = 1'b0;
   endtask

   task automatic wait_q(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk_100M); #1;
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_drain();
      wait_q(200);
      @(posedge clk_100M); #1;
   endtask

   always @(negedge clk_100M) begin
      if (nrst) begin
         if (tx_full) check("no_wr_when_full", 32'(tx_wrreq), 32'd0);
         if (tx_wrreq) begin
            if (exp_q.size() == 0) check("spurious_wr", 32'(tx_wrreq), 32'd0);
            else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk_100M);
      #1;
      check("rst_wrreq", 32'(tx_wrreq), 32'd0);
      check("rst_data", 32'(tx_data), 32'd0);
      check("rst_line", 32'(line_cnt), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      nrst = 1'b1;
      en   = 1'b1;
      repeat (2) @(posedge clk_100M);
      #1;

      // single line with latency checks
      px_q = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
      push_frame(16'h0000);
      pix_valid = 1'b1;
      pix_data  = 16'h1234;
      @(posedge clk_100M); #1;
      check("lat_idle", 32'(tx_wrreq), 32'd0);
      pix_data = 16'hABCD;
      @(posedge clk_100M); #1;
      check("lat_hdr0_wr", 32'(tx_wrreq), 32'd1);
      check("lat_hdr0_data", 32'(tx_data), 32'hA5);
      pix_data = 16'h0001;
      @(posedge clk_100M); #1;
      pix_data = 16'hFF00;
      @(posedge clk_100M); #1;
      pix_valid = 1'b0;
      wait_drain();
      check("line_after_1", 32'(line_cnt), 32'd1);

      // backpressure: alternate in header, 3 cycles held in PXL
      push_frame(16'h0001);
      tx_full = 1'b1;
      foreach (px_q[i]) push_pix(px_q[i]);
      for (int i = 0; i < 12; i++) begin
         tx_full = full_pat[i];
         @(posedge clk_100M); #1;
      end
      tx_full = 1'b0;
      wait_drain();
      check("line_after_2", 32'(line_cnt), 32'd2);

      // overflow with the sink blocked
      ovf_px = '{16'h0F0F, 16'h1357, 16'h2468, 16'h8001, 16'hDEAD, 16'hBEEF};
      px_q = '{16'h0F0F, 16'h1357, 16'h2468, 16'h8001};
      push_frame(16'h0002);
      tx_full = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push_pix(ovf_px[i]);
         if (i == 3) check("ovf_after_4", 32'(ovf), 32'd0);
         if (i == 4) check("ovf_after_5", 32'(ovf), 32'd1);
      end
      tx_full = 1'b0;
      wait_drain();
      check("ovf_sticky", 32'(ovf), 32'd1);
      check("line_after_3", 32'(line_cnt), 32'd3);

      // en rising edge in IDLE clears line count and overflow
      en = 1'b0;
      @(posedge clk_100M); #1;
      en = 1'b1;
      @(posedge clk_100M); #1;
      check("clr_line", 32'(line_cnt), 32'd0);
      check("clr_ovf", 32'(ovf), 32'd0);

      // truncated line padded with zeros
      px_q = '{16'hC3A5, 16'h7E81, 16'h0000, 16'h0000};
      push_frame(16'h0000);
      push_pix(16'hC3A5);
      push_pix(16'h7E81);
      en = 1'b0;
      wait_drain();
      check("line_after_trunc", 32'(line_cnt), 32'd1);
      en = 1'b1;
      @(posedge clk_100M); #1;
      check("clr_after_trunc", 32'(line_cnt), 32'd0);

      // line counter wrap
      force dut.line_cnt = 16'hFFFF;
      #1;
      release dut.line_cnt;
      px_q = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
      push_frame(16'hFFFF);
      foreach (px_q[i]) push_pix(px_q[i]);
      wait_drain();
      check("line_wrap", 32'(line_cnt), 32'd0);

      // reset in the middle of PXH
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h42);
      exp_q.push_back(8'h43);
      push_pix(16'h4243);
      push_pix(16'h9988);
      wait_q(200);
      check("pre_rst_wr", 32'(tx_wrreq), 32'd1);
      check("pre_rst_data", 32'(tx_data), 32'h99);
      nrst = 1'b0;
      #1;
      check("rst_mid_wrreq", 32'(tx_wrreq), 32'd0);
      check("rst_mid_data", 32'(tx_data), 32'd0);
      @(posedge clk_100M); #1;
      nrst = 1'b1;
      @(posedge clk_100M); #1;
      px_q = '{16'h0BAD, 16'hCAFE, 16'h5555, 16'hAAAA};
      push_frame(16'h0000);
      foreach (px_q[i]) push_pix(px_q[i]);
      wait_drain();
      check("line_after_rst", 32'(line_cnt), 32'd1);

      repeat (3) @(posedge clk_100M);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
